// File: rtl/layer_data_wr_pkg.sv
// Shared constants and state encoding for the layer pixel-RAM feeder.
package layer_pkg;

   localparam logic [7:0] CMD_CONF  = 8'h2A;
   localparam logic [7:0] CMD_DATA  = 8'h2C;
   localparam int         PIXEL_NUM = 64;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      CONF,
      DATA,
      DISCARD
   } state_t;

endpackage

// File: rtl/layer_data_wr.sv
// Parses a chip-select framed SPI byte stream into pixel RAM writes and
// WS281x bit-timing configuration for one output layer.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no frame; counters cleared, waits for cs_n low after a cs_n high
// CMD     | waiting for the command byte of the frame
// CONF    | collecting the four timing bytes t0h, t0l, t1h, t1l
// DATA    | writing pixel bytes lane by lane, pixel by pixel
// DISCARD | bad command; rest of frame ignored
module layer_data_wr
   import layer_pkg::*;
#(
   parameter int         BPP     = 3,
   parameter logic [7:0] T0H_DEF = 8'd16,
   parameter logic [7:0] T0L_DEF = 8'd44,
   parameter logic [7:0] T1H_DEF = 8'd44,
   parameter logic [7:0] T1L_DEF = 8'd16
) (
   input  logic       clk_in,
   input  logic       rst_n_in,
   input  logic       spi_cs_n_in,
   input  logic       spi_byte_vld_in,
   input  logic [7:0] spi_byte_data_in,
   output logic       wr_en_out,
   output logic       wr_done_out,
   output logic [5:0] wr_addr_out,
   output logic [7:0] wr_data_out,
   output logic [3:0] wr_byte_en_out,
   output logic [7:0] t0h_cnt_out,
   output logic [7:0] t0l_cnt_out,
   output logic [7:0] t1h_cnt_out,
   output logic [7:0] t1l_cnt_out,
   output logic       frame_err_out
);

   state_t     state, state_nxt;
   logic       accept;
   logic       armed;       // cs_n seen high since reset; blocks a frame cut by reset
   logic [1:0] idx;         // byte lane within the current pixel
   logic [5:0] addr;        // current pixel address
   logic       wrote;
   logic       ovf;
   logic       ovf_err;
   logic [2:0] conf_cnt;
   logic [7:0] sh_t0h, sh_t0l, sh_t1h;
   logic       last_lane;
   logic       last_pixel;

   assign accept     = spi_byte_vld_in & ~spi_cs_n_in;
   assign last_lane  = (idx == 2'(BPP - 1));
   assign last_pixel = (addr == 6'(PIXEL_NUM - 1));

   // State register.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) state <= IDLE;
      else           state <= state_nxt;
   end

   // Next-state: cs_n high always ends the frame.
   always_comb begin
      state_nxt = state;
      if (spi_cs_n_in) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: if (armed) state_nxt = CMD;
            CMD: begin
               if (accept) begin
                  if (spi_byte_data_in == CMD_CONF)      state_nxt = CONF;
                  else if (spi_byte_data_in == CMD_DATA) state_nxt = DATA;
                  else                                   state_nxt = DISCARD;
               end
            end
            default: state_nxt = state;
         endcase
      end
   end

   // Datapath: counters, shadow timing registers and registered outputs.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         wr_en_out      <= 1'b0;
         wr_done_out    <= 1'b0;
         frame_err_out  <= 1'b0;
         wr_addr_out    <= '0;
         wr_data_out    <= '0;
         wr_byte_en_out <= '0;
         t0h_cnt_out    <= T0H_DEF;
         t0l_cnt_out    <= T0L_DEF;
         t1h_cnt_out    <= T1H_DEF;
         t1l_cnt_out    <= T1L_DEF;
         sh_t0h         <= '0;
         sh_t0l         <= '0;
         sh_t1h         <= '0;
         armed          <= 1'b0;
         idx            <= '0;
         addr           <= '0;
         wrote          <= 1'b0;
         ovf            <= 1'b0;
         ovf_err        <= 1'b0;
         conf_cnt       <= '0;
      end else begin
         wr_en_out     <= 1'b0;
         wr_done_out   <= 1'b0;
         frame_err_out <= 1'b0;
         if (spi_cs_n_in) armed <= 1'b1;
         if (spi_cs_n_in && (state == DATA) && wrote) wr_done_out <= 1'b1;
         case (state)
            IDLE: begin
               idx      <= '0;
               addr     <= '0;
               wrote    <= 1'b0;
               ovf      <= 1'b0;
               ovf_err  <= 1'b0;
               conf_cnt <= '0;
            end
            CMD: begin
               if (accept && (spi_byte_data_in != CMD_CONF) && (spi_byte_data_in != CMD_DATA))
                  frame_err_out <= 1'b1;
            end
            CONF: begin
               if (accept && (conf_cnt != 3'd4)) begin
                  conf_cnt <= conf_cnt + 3'd1;
                  case (conf_cnt)
                     3'd0:    sh_t0h <= spi_byte_data_in;
                     3'd1:    sh_t0l <= spi_byte_data_in;
                     3'd2:    sh_t1h <= spi_byte_data_in;
                     default: begin
                        // all four counts switch together so the output stage never sees a mix
                        t0h_cnt_out <= sh_t0h;
                        t0l_cnt_out <= sh_t0l;
                        t1h_cnt_out <= sh_t1h;
                        t1l_cnt_out <= spi_byte_data_in;
                     end
                  endcase
               end
            end
            DATA: begin
               if (accept) begin
                  if (!ovf) begin
                     wr_en_out      <= 1'b1;
                     wr_data_out    <= spi_byte_data_in;
                     wr_byte_en_out <= 4'b0001 << idx;
                     wr_addr_out    <= addr;
                     wrote          <= 1'b1;
                     if (last_lane) begin
                        idx  <= '0;
                        addr <= addr + 6'd1;
                        if (last_pixel) ovf <= 1'b1;
                     end else begin
                        idx <= idx + 2'd1;
                     end
                  end else if (!ovf_err) begin
                     frame_err_out <= 1'b1;
                     ovf_err       <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_layer_data_wr.sv
// Randomized self-checking bench for layer_data_wr with a frame-level model.
module tb_layer_data_wr;

   localparam int         BPP     = 3;
   localparam logic [7:0] T0H_DEF = 8'd16;
   localparam logic [7:0] T0L_DEF = 8'd44;
   localparam logic [7:0] T1H_DEF = 8'd44;
   localparam logic [7:0] T1L_DEF = 8'd16;
   localparam logic [31:0] T_DEF  = {T0H_DEF, T0L_DEF, T1H_DEF, T1L_DEF};

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cs_n;
   logic       vld;
   logic [7:0] data;
   logic       wr_en, wr_done, frame_err;
   logic [5:0] wr_addr;
   logic [7:0] wr_data;
   logic [3:0] wr_byte_en;
   logic [7:0] t0h, t0l, t1h, t1l;
   logic [31:0] timing;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   logic [17:0] obs_wr[$];
   int          done_cnt, err_cnt, chg_cnt;
   int          last_wr_cyc, done_cyc, chg_cyc;
   logic [31:0] prev_timing;
   logic [31:0] t_exp;

   assign timing = {t0h, t0l, t1h, t1l};

   layer_data_wr #(
      .BPP(BPP), .T0H_DEF(T0H_DEF), .T0L_DEF(T0L_DEF), .T1H_DEF(T1H_DEF), .T1L_DEF(T1L_DEF)
   ) dut (
      .clk_in(clk), .rst_n_in(rst_n), .spi_cs_n_in(cs_n), .spi_byte_vld_in(vld),
      .spi_byte_data_in(data), .wr_en_out(wr_en), .wr_done_out(wr_done),
      .wr_addr_out(wr_addr), .wr_data_out(wr_data), .wr_byte_en_out(wr_byte_en),
      .t0h_cnt_out(t0h), .t0l_cnt_out(t0l), .t1h_cnt_out(t1h), .t1l_cnt_out(t1l),
      .frame_err_out(frame_err)
   );

   // 10 ns clock.
   always #5 clk = ~clk;

   // Cycle counter for timing relationships.
   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (wr_en) begin
         obs_wr.push_back({wr_addr, wr_byte_en, wr_data});
         last_wr_cyc = cyc;
      end
      if (wr_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (frame_err) err_cnt++;
      if (timing != prev_timing) begin
         chg_cnt++;
         chg_cyc     = cyc;
         prev_timing = timing;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] v);
      data = v;
      vld  = 1'b1;
      tick();
      vld  = 1'b0;
   endtask

   task automatic clear_mon();
      obs_wr.delete();
      done_cnt    = 0;
      err_cnt     = 0;
      chg_cnt     = 0;
      last_wr_cyc = 0;
      done_cyc    = 0;
      chg_cyc     = 0;
      prev_timing = timing;
   endtask

   task automatic chk_defaults(input string tag);
      chk({tag, "_timing"}, timing, T_DEF);
      chk({tag, "_strobes"}, {29'd0, wr_en, wr_done, frame_err}, 32'd0);
      chk({tag, "_addr"}, {26'd0, wr_addr}, 32'd0);
      chk({tag, "_data"}, {24'd0, wr_data}, 32'd0);
      chk({tag, "_lane"}, {28'd0, wr_byte_en}, 32'd0);
   endtask

   // One frame: model the expected effect, drive it, compare.
   task automatic run_frame(input logic [7:0] b[$], input bit cs_last);
      logic [7:0]  acc[$];
      logic [17:0] exp_wr[$];
      logic [31:0] new_t;
      int          exp_err, exp_done, n, conf_cyc;
      acc = b;
      if (cs_last && acc.size() > 0) acc.delete(acc.size() - 1);
      new_t    = t_exp;
      exp_err  = 0;
      conf_cyc = -1;
      if (acc.size() > 0) begin
         if (acc[0] == 8'h2A) begin
            if (acc.size() >= 5) new_t = {acc[1], acc[2], acc[3], acc[4]};
         end else if (acc[0] == 8'h2C) begin
            for (int i = 1; i < acc.size(); i++) begin
               n = i - 1;
               if (n < 64 * BPP) exp_wr.push_back({6'(n / BPP), 4'(1 << (n % BPP)), acc[i]});
               else              exp_err = 1;
            end
         end else begin
            exp_err = 1;
         end
      end
      exp_done = (exp_wr.size() > 0) ? 1 : 0;

      clear_mon();
      cs_n = 1'b0;
      tick();
      tick();
      foreach (b[i]) begin
         repeat ($urandom_range(0, 2)) tick();
         if (cs_last && i == b.size() - 1) cs_n = 1'b1;
         send_byte(b[i]);
         if (i == 4) conf_cyc = cyc;
      end
      cs_n = 1'b1;
      repeat (4) tick();

      chk("n_writes", obs_wr.size(), exp_wr.size());
      for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++)
         chk($sformatf("write%0d", i), {14'd0, obs_wr[i]}, {14'd0, exp_wr[i]});
      chk("frame_err", err_cnt, exp_err);
      chk("wr_done", done_cnt, exp_done);
      chk("timing", timing, new_t);
      chk("timing_changes", chg_cnt, (new_t != t_exp) ? 1 : 0);
      if (new_t != t_exp) chk("timing_change_cyc", chg_cyc, conf_cyc);
      if (exp_done != 0) chk("done_after_write", (done_cyc > last_wr_cyc) ? 1 : 0, 1);
      t_exp = new_t;
   endtask

   initial begin
      logic [7:0] q[$];
      logic [7:0] v;
      int         r;
      rst_n = 1'b0;
      cs_n  = 1'b1;
      vld   = 1'b0;
      data  = 8'h00;
      t_exp = T_DEF;
      repeat (3) tick();
      chk_defaults("reset");
      rst_n = 1'b1;
      tick();

      // strobes while cs_n high must be ignored
      clear_mon();
      repeat (5) send_byte(8'($urandom));
      tick();
      chk("cs_high_writes", obs_wr.size(), 0);
      chk("cs_high_err", err_cnt, 0);

      q = {8'h2A, 8'h10, 8'h20, 8'h30, 8'h40};
      run_frame(q, 1'b0);
      chk("conf_fixed", timing, 32'h10203040);

      q = {8'h2C, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      run_frame(q, 1'b0);

      // full RAM plus two overflow bytes
      q.delete();
      q.push_back(8'h2C);
      repeat (64 * BPP + 2) q.push_back(8'($urandom));
      run_frame(q, 1'b0);

      q = {8'h55, 8'h01, 8'h02, 8'h03};
      run_frame(q, 1'b0);

      // cs_n rises together with the third data strobe
      q = {8'h2C, 8'h11, 8'h22, 8'h33};
      run_frame(q, 1'b1);

      // async reset in the middle of a data frame
      clear_mon();
      cs_n = 1'b0;
      tick();
      tick();
      send_byte(8'h2C);
      send_byte(8'h5A);
      send_byte(8'hA5);
      tick();
      rst_n = 1'b0;
      #2;
      chk_defaults("mid_reset");
      tick();
      rst_n = 1'b1;
      clear_mon();
      send_byte(8'h33);
      send_byte(8'h44);
      send_byte(8'h55);
      tick();
      cs_n = 1'b1;
      repeat (4) tick();
      chk("post_reset_writes", obs_wr.size(), 0);
      chk("post_reset_done", done_cnt, 0);
      chk("post_reset_err", err_cnt, 0);
      t_exp = T_DEF;

      // random frames
      for (int k = 0; k < 12; k++) begin
         r = $urandom_range(0, 3);
         if (r == 0)      v = 8'h2A;
         else if (r < 3)  v = 8'h2C;
         else begin
            v = 8'($urandom);
            if (v == 8'h2A || v == 8'h2C) v = 8'h00;
         end
         q.delete();
         q.push_back(v);
         repeat ($urandom_range(0, 10)) q.push_back(8'($urandom));
         run_frame(q, ($urandom_range(0, 3) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
